// File: rtl/gen_sram_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen_sram_pkg
// Purpose  : Shared types, constants and helpers for the gen_sram_fwd SRAM.
//            Holds the controller state encoding, lane geometry and the
//            legal read-latency range.
// Revision : 1.0 - initial release
// ============================================================================
package gen_sram_pkg;

  // Every storage lane is one byte wide; the top lane may be partially used.
  localparam int c_LANE_W     = 8;

  // Legal read-latency range (inclusive).
  localparam int c_RD_LAT_MIN = 1;
  localparam int c_RD_LAT_MAX = 2;

  // Controller state: zero sweep in progress, or normal operation.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_st_e;

  // Number of byte lanes needed to cover a data word of dw bits.
  function automatic int lanes(input int dw);
    return (dw + c_LANE_W - 1) / c_LANE_W;
  endfunction

  // True when the requested read latency is supported.
  function automatic bit rd_lat_legal(input int lat);
    return (lat >= c_RD_LAT_MIN) && (lat <= c_RD_LAT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen_sram_fwd_if.sv
`default_nettype none
// ============================================================================
// Module   : gen_sram_fwd_if
// Purpose  : Request/response bundle for gen_sram_fwd.
// Ports    : data_w/addr_w/data_wstrb/en_w  write request
//            addr_r/en_r                     read request
//            clear                           re-zero request
//            data_r/valid_r                  read response
//            init_done                       array usable
//            master = requester side, slave = SRAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface gen_sram_fwd_if
  import gen_sram_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 14
) ();

  localparam int NL = lanes(DW);

  logic [DW-1:0] data_w;
  logic [AW-1:0] addr_w;
  logic [NL-1:0] data_wstrb;
  logic          en_w;
  logic [AW-1:0] addr_r;
  logic          en_r;
  logic          clear;
  logic [DW-1:0] data_r;
  logic          valid_r;
  logic          init_done;

  modport master (
    output data_w, addr_w, data_wstrb, en_w, addr_r, en_r, clear,
    input  data_r, valid_r, init_done
  );

  modport slave (
    input  data_w, addr_w, data_wstrb, en_w, addr_r, en_r, clear,
    output data_r, valid_r, init_done
  );

endinterface
`default_nettype wire

// File: rtl/gen_sram_fwd_lane.sv
`default_nettype none
// ============================================================================
// Module   : gen_sram_lane
// Purpose  : One byte-wide, 2**AW-deep storage lane with a write port and a
//            registered read port. A same-edge read returns the old contents.
// Ports    : CLK, RST   clock, async active-high reset (read register only)
//            we/waddr/wdata   write port
//            re/raddr/rdata   read port, rdata updates only when re is set
// Revision : 1.0 - initial release
// ============================================================================
module gen_sram_lane
  import gen_sram_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [c_LANE_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [c_LANE_W-1:0] rdata
);

  localparam int DP = 2 ** AW;

  // Storage is deliberately not reset; the sweep engine defines it.
  logic [c_LANE_W-1:0] r_mem [0:DP-1];
  logic [c_LANE_W-1:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/gen_sram_fwd.sv
`default_nettype none
// ============================================================================
// Module   : gen_sram_fwd
// Purpose  : Simple-dual-port SRAM with byte strobes, 1- or 2-cycle read
//            latency, same-cycle write-to-read forwarding and a hardware
//            zero-initialisation sweep after reset or on clear.
// Ports    : CLK   rising-edge clock
//            RST   asynchronous active-high reset
//            bus   gen_sram_fwd_if.slave (requests, read data, init_done)
// Revision : 1.0 - initial release
// ============================================================================
module gen_sram_fwd
  import gen_sram_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 14,
  parameter int RD_LAT    = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic          CLK,
  input  logic          RST,
  gen_sram_fwd_if.slave bus
);

  localparam int            NL     = lanes(DW);
  localparam int            PW     = NL * c_LANE_W;
  localparam logic [AW-1:0] c_LAST = {AW{1'b1}};

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("gen_sram_fwd: RD_LAT must be 1 or 2");
  end

  // --------------------------------------------------------------------------
  // Controller: INIT sweeps one address per cycle, RUN serves requests.
  // --------------------------------------------------------------------------
  sram_st_e      r_state;
  logic [AW-1:0] r_cnt;
  logic          r_init_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= (INIT_ZERO != 0) ? INIT : RUN;
      r_cnt       <= '0;
      r_init_done <= (INIT_ZERO == 0);
    end else begin
      case (r_state)
        INIT: begin
          if (r_cnt == c_LAST) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if ((INIT_ZERO != 0) && bus.clear) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.init_done = r_init_done;

  // --------------------------------------------------------------------------
  // Request acceptance and write-port mux (sweep has priority; user
  // requests are never accepted while sweeping anyway).
  // --------------------------------------------------------------------------
  logic          w_sweep;
  logic          w_acc_w;
  logic          w_acc_r;
  logic          w_coll;
  logic [PW-1:0] w_wdata_pad;
  logic [PW-1:0] w_lane_wdata;
  logic [AW-1:0] w_waddr;
  logic [NL-1:0] w_lane_we;
  logic [NL-1:0] w_fwd_mask;
  logic [PW-1:0] w_lane_rdata;

  assign w_sweep = (r_state == INIT);
  assign w_acc_w = bus.en_w & r_init_done;
  assign w_acc_r = bus.en_r & r_init_done;
  assign w_coll  = w_acc_w & w_acc_r & (bus.addr_w == bus.addr_r);

  // Zero-extend so padding bits of a partial top lane are stored as 0.
  always_comb begin
    w_wdata_pad         = '0;
    w_wdata_pad[DW-1:0] = bus.data_w;
  end

  assign w_lane_wdata = w_sweep ? '0 : w_wdata_pad;
  assign w_waddr      = w_sweep ? r_cnt : bus.addr_w;
  assign w_fwd_mask   = ((BYPASS != 0) && w_coll) ? bus.data_wstrb : '0;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    assign w_lane_we[gi] = w_sweep | (w_acc_w & bus.data_wstrb[gi]);

    gen_sram_lane #(
      .AW (AW)
    ) u_lane (
      .CLK   (CLK),
      .RST   (RST),
      .we    (w_lane_we[gi]),
      .waddr (w_waddr),
      .wdata (w_lane_wdata[gi*c_LANE_W +: c_LANE_W]),
      .re    (w_acc_r),
      .raddr (bus.addr_r),
      .rdata (w_lane_rdata[gi*c_LANE_W +: c_LANE_W])
    );
  end

  // --------------------------------------------------------------------------
  // First read stage. The lanes return old data on a same-edge collision;
  // the captured forward mask/data overlay the strobed lanes afterwards.
  // Both registers update only on an accepted read so data_r holds.
  // --------------------------------------------------------------------------
  logic [NL-1:0] r_fwd_mask;
  logic [PW-1:0] r_fwd_data;
  logic          r_v1;
  logic [PW-1:0] w_d1_pad;
  logic [DW-1:0] w_d1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
      r_v1       <= 1'b0;
    end else begin
      r_v1 <= w_acc_r;
      if (w_acc_r) begin
        r_fwd_mask <= w_fwd_mask;
        r_fwd_data <= w_wdata_pad;
      end
    end
  end

  for (genvar gi = 0; gi < NL; gi++) begin : g_fwd
    assign w_d1_pad[gi*c_LANE_W +: c_LANE_W] = r_fwd_mask[gi]
        ? r_fwd_data[gi*c_LANE_W +: c_LANE_W]
        : w_lane_rdata[gi*c_LANE_W +: c_LANE_W];
  end

  assign w_d1 = w_d1_pad[DW-1:0];

  if (PW > DW) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_d1_pad[PW-1:DW];
  end

  // --------------------------------------------------------------------------
  // Optional second stage: a plain register copy of stage one.
  // --------------------------------------------------------------------------
  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] r_d2;
    logic          r_v2;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_d2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_d2 <= w_d1;
        end
      end
    end

    assign bus.data_r  = r_d2;
    assign bus.valid_r = r_v2;
  end else begin : g_lat1
    assign bus.data_r  = w_d1;
    assign bus.valid_r = r_v1;
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_sram_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_sram_fwd
// Purpose  : Directed self-checking bench for gen_sram_fwd. Three DW=32/AW=4
//            instances share one stimulus (RD_LAT1/BYPASS1, RD_LAT1/BYPASS0,
//            RD_LAT2/BYPASS1); a fourth DW=12 instance has its own stimulus
//            and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_sram_fwd;

  logic CLK = 1'b0;
  logic RST;
  logic rst3;

  always #5 CLK = ~CLK;

  // Shared stimulus for the DW=32 instances.
  logic [31:0] data_w;
  logic [3:0]  addr_w;
  logic [3:0]  strb;
  logic        en_w;
  logic [3:0]  addr_r;
  logic        en_r;
  logic        clear;

  // Stimulus for the DW=12 instance.
  logic [11:0] d3_w;
  logic [3:0]  a3_w;
  logic [1:0]  s3;
  logic        ew3;
  logic [3:0]  a3_r;
  logic        er3;
  logic        clr3;

  gen_sram_fwd_if #(.DW(32), .AW(4)) if0 ();
  gen_sram_fwd_if #(.DW(32), .AW(4)) if1 ();
  gen_sram_fwd_if #(.DW(32), .AW(4)) if2 ();
  gen_sram_fwd_if #(.DW(12), .AW(4)) if3 ();

  assign {if0.data_w, if0.addr_w, if0.data_wstrb, if0.en_w, if0.addr_r, if0.en_r, if0.clear}
       = {data_w, addr_w, strb, en_w, addr_r, en_r, clear};
  assign {if1.data_w, if1.addr_w, if1.data_wstrb, if1.en_w, if1.addr_r, if1.en_r, if1.clear}
       = {data_w, addr_w, strb, en_w, addr_r, en_r, clear};
  assign {if2.data_w, if2.addr_w, if2.data_wstrb, if2.en_w, if2.addr_r, if2.en_r, if2.clear}
       = {data_w, addr_w, strb, en_w, addr_r, en_r, clear};
  assign {if3.data_w, if3.addr_w, if3.data_wstrb, if3.en_w, if3.addr_r, if3.en_r, if3.clear}
       = {d3_w, a3_w, s3, ew3, a3_r, er3, clr3};

  gen_sram_fwd #(.DW(32), .AW(4), .RD_LAT(1), .BYPASS(1), .INIT_ZERO(1))
    u_dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  gen_sram_fwd #(.DW(32), .AW(4), .RD_LAT(1), .BYPASS(0), .INIT_ZERO(1))
    u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));
  gen_sram_fwd #(.DW(32), .AW(4), .RD_LAT(2), .BYPASS(1), .INIT_ZERO(1))
    u_dut2 (.CLK(CLK), .RST(RST), .bus(if2));
  gen_sram_fwd #(.DW(12), .AW(4), .RD_LAT(1), .BYPASS(1), .INIT_ZERO(1))
    u_dut3 (.CLK(CLK), .RST(rst3), .bus(if3));

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    en_w   = 1'b1;
    addr_w = a;
    data_w = d;
    strb   = s;
  endtask

  initial begin
    RST = 1'b1; rst3 = 1'b1;
    data_w = '0; addr_w = '0; strb = '0; en_w = 1'b0; addr_r = '0; en_r = 1'b0; clear = 1'b0;
    d3_w = '0; a3_w = '0; s3 = '0; ew3 = 1'b0; a3_r = '0; er3 = 1'b0; clr3 = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    check("rst_data_r",    if0.data_r,    32'h0);
    check("rst_valid_r",   if0.valid_r,   32'h0);
    check("rst_init_done", if0.init_done, 32'h0);
    check("rst_l2_valid",  if2.valid_r,   32'h0);

    // ---- reset sweep: init_done rises exactly 16 cycles after release ----
    RST = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k >= 15) begin
        check("sweep_done0", if0.init_done, 32'(k == 16));
        check("sweep_done1", if1.init_done, 32'(k == 16));
        check("sweep_done2", if2.init_done, 32'(k == 16));
      end
    end

    // ---- read all addresses back-to-back: zeros, valid every cycle ----
    en_r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr_r = i[3:0];
      @(negedge CLK);
      check("sweep_rd_valid", if0.valid_r, 32'h1);
      check("sweep_rd_data",  if0.data_r,  32'h0);
      if (i > 0) check("sweep_rd_l2_valid", if2.valid_r, 32'h1);
    end
    en_r = 1'b0;
    @(negedge CLK);
    check("sweep_l2_tail", if2.valid_r, 32'h1);
    check("sweep_l1_idle", if0.valid_r, 32'h0);

    // ---- strobed write ----
    wr(4'd3, 32'hAABB_CCDD, 4'b1111);
    @(negedge CLK);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    @(negedge CLK);
    en_w = 1'b0; en_r = 1'b1; addr_r = 4'd3;
    @(negedge CLK);
    check("strb_d0", if0.data_r,  32'hAA22_CC44);
    check("strb_v0", if0.valid_r, 32'h1);
    check("strb_d1", if1.data_r,  32'hAA22_CC44);
    en_r = 1'b0;
    @(negedge CLK);
    check("strb_l2_d", if2.data_r,  32'hAA22_CC44);
    check("strb_l2_v", if2.valid_r, 32'h1);
    check("strb_hold", if0.data_r,  32'hAA22_CC44);
    check("strb_v_lo", if0.valid_r, 32'h0);

    // ---- collision on addr 5 ----
    wr(4'd5, 32'hDEAD_BEEF, 4'b0011); en_r = 1'b1; addr_r = 4'd5;
    @(negedge CLK);
    check("coll_byp1", if0.data_r, 32'h0000_BEEF);
    check("coll_byp0", if1.data_r, 32'h0000_0000);
    check("coll_v1",   if1.valid_r, 32'h1);
    en_w = 1'b0;
    @(negedge CLK);
    check("coll_after_byp1", if0.data_r, 32'h0000_BEEF);
    check("coll_after_byp0", if1.data_r, 32'h0000_BEEF);
    check("coll_l2",         if2.data_r, 32'h0000_BEEF);
    // Read then write the same address on the next edge (RD_LAT=2 in flight).
    @(negedge CLK);
    en_r = 1'b0;
    wr(4'd5, 32'h1234_5678, 4'b1111);
    @(negedge CLK);
    en_w = 1'b0;
    check("raw_next_l2_d", if2.data_r,  32'h0000_BEEF);
    check("raw_next_l2_v", if2.valid_r, 32'h1);
    check("raw_next_l1_v", if0.valid_r, 32'h0);
    en_r = 1'b1; addr_r = 4'd5;
    @(negedge CLK);
    en_r = 1'b0;
    check("raw_landed", if0.data_r, 32'h1234_5678);

    // ---- RD_LAT=2 pipeline: reads 1,2,3 back-to-back ----
    wr(4'd1, 32'h1111_1111, 4'b1111);
    @(negedge CLK);
    wr(4'd2, 32'h2222_2222, 4'b1111);
    @(negedge CLK);
    en_w = 1'b0; en_r = 1'b1; addr_r = 4'd1;
    @(negedge CLK);
    check("l2_n1_v", if2.valid_r, 32'h0);
    check("l1_n1_d", if0.data_r, 32'h1111_1111);
    addr_r = 4'd2;
    @(negedge CLK);
    check("l2_a1_v", if2.valid_r, 32'h1);
    check("l2_a1_d", if2.data_r,  32'h1111_1111);
    addr_r = 4'd3;
    @(negedge CLK);
    check("l2_a2_v", if2.valid_r, 32'h1);
    check("l2_a2_d", if2.data_r,  32'h2222_2222);
    en_r = 1'b0;
    @(negedge CLK);
    check("l2_a3_v", if2.valid_r, 32'h1);
    check("l2_a3_d", if2.data_r,  32'hAA22_CC44);
    @(negedge CLK);
    check("l2_end_v",    if2.valid_r, 32'h0);
    check("l2_end_hold", if2.data_r,  32'hAA22_CC44);

    // ---- clear in RUN (same-cycle read completes normally) ----
    clear = 1'b1; en_r = 1'b1; addr_r = 4'd3;
    @(negedge CLK);
    clear = 1'b0;
    check("clr_rd_v",  if0.valid_r,   32'h1);
    check("clr_rd_d",  if0.data_r,    32'hAA22_CC44);
    check("clr_done0", if0.init_done, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      check("clr_init_no_valid", if0.valid_r, 32'h0);
      if (k >= 15) check("clr_done_rise", if0.init_done, 32'(k == 16));
    end
    for (int i = 0; i < 16; i++) begin
      addr_r = i[3:0];
      @(negedge CLK);
      check("clr_rd_valid", if0.valid_r, 32'h1);
      check("clr_rd_zero",  if0.data_r,  32'h0);
    end
    en_r = 1'b0;

    // ---- DW=12 instance: partial top lane ----
    rst3 = 1'b0;
    repeat (16) @(negedge CLK);
    check("dw12_done", if3.init_done, 32'h1);
    ew3 = 1'b1; a3_w = 4'd2; d3_w = 12'hFFF; s3 = 2'b10;
    @(negedge CLK);
    ew3 = 1'b0; er3 = 1'b1; a3_r = 4'd2;
    @(negedge CLK);
    er3 = 1'b0;
    check("dw12_strb_d", if3.data_r,  32'h0000_0F00);
    check("dw12_strb_v", if3.valid_r, 32'h1);
    // Async reset clears the read pipeline immediately.
    rst3 = 1'b1;
    #1;
    check("dw12_rst_v",    if3.valid_r,   32'h0);
    check("dw12_rst_d",    if3.data_r,    32'h0);
    check("dw12_rst_done", if3.init_done, 32'h0);
    @(negedge CLK);
    rst3 = 1'b0;
    repeat (5) @(negedge CLK);
    check("dw12_mid_done", if3.init_done, 32'h0);
    rst3 = 1'b1;
    @(negedge CLK);
    rst3 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k >= 15) check("dw12_restart_done", if3.init_done, 32'(k == 16));
    end
    er3 = 1'b1; a3_r = 4'd2;
    @(negedge CLK);
    er3 = 1'b0;
    check("dw12_swept_v", if3.valid_r, 32'h1);
    check("dw12_swept_d", if3.data_r,  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gen_sram_fwd.md
# gen_sram_fwd

Parametrised simple-dual-port SRAM with per-byte write strobes, selectable read latency, write-to-read forwarding on address collision, and a hardware zero-initialisation engine. It is the successor to the testbench SRAM model used behind the core's memory ports. It removes the random/undefined power-up contents by sweeping the array after reset or on request. It adds a read-valid strobe so consumers no longer count cycles themselves.

## Interface
- `DW`, 32: data width in bits. Any value ≥1. Lanes = (DW+7)/8; the top lane is partial when DW%8≠0.
- `AW`, 14: address width. Depth DP = 2**AW.
- `RD_LAT`, 1: read latency in cycles. Legal values are 1 or 2; any other value is an elaboration error.
- `BYPASS`, 1: 1 = write-first forwarding on same-cycle collision; 0 = read-first (old data).
- `INIT_ZERO`, 1: 1 = zero-sweep the array after reset and on `clear`; 0 = no init engine.
- `CLK`, in, 1: single clock; all logic is rising-edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `data_w`, in, DW: write data.
- `addr_w`, in, AW: write address.
- `data_wstrb`, in, (DW+7)/8: byte-lane write enables. Bit i covers bits [i*8+:8].
- `en_w`, in, 1: write request.
- `addr_r`, in, AW: read address.
- `en_r`, in, 1: read request.
- `data_r`, out, DW: read data. Holds its last value when no read completes.
- `valid_r`, out, 1: one-cycle pulse marking a completed read on `data_r`.
- `clear`, in, 1: single-cycle request to re-zero the array. Used only when INIT_ZERO=1.
- `init_done`, out, 1: array is usable; requests are accepted only while this is high.

## Operation
- FSM states are INIT and RUN.
  - Reset enters INIT when INIT_ZERO=1, otherwise RUN.
  - INIT: the sweep counter starts at 0 and writes all-zero, full-strobe, to one address per cycle. After writing DP-1 it goes to RUN on the next edge.
  - RUN with `clear`=1: next state is INIT and the counter restarts at 0. `clear` is ignored in INIT and when INIT_ZERO=0.
- `init_done` = (state==RUN). It is registered, so it is high from the cycle after the last sweep write.
- Requests while `init_done`=0 are dropped silently: no array update and no `valid_r`.
- A read or write accepted in the same cycle that `clear` is sampled completes normally. The sweep then overwrites it.
- Write: for each lane i with `data_wstrb`[i]=1, ram[addr_w] lane i takes `data_w` lane i. Unstrobed lanes are untouched. Bits beyond DW in the partial lane are stored as 0.
- Read: ram[addr_r] is captured at acceptance.
- Collision (`en_w` & `en_r` & addr_w==addr_r, same cycle):
  - BYPASS=1: strobed lanes return the new write data; unstrobed lanes return old data.
  - BYPASS=0: all lanes return old data.
- A write in the cycle after a read to the same address never affects that read, including when RD_LAT=2.
- The array is not reset; its contents are defined only after an INIT sweep or explicit writes.

## Timing
- RD_LAT=1: `en_r` accepted at edge N → `data_r` and `valid_r`=1 during cycle N+1.
- RD_LAT=2: the same, one cycle later. The second stage is a pure register stage.
- Back-to-back reads sustain one result per cycle.
- `valid_r` is high for exactly one cycle per accepted read.
- Write is visible to a non-colliding read accepted on the next edge.
- INIT lasts exactly DP cycles after reset deassertion (or after `clear`) before `init_done` rises.
- `RST` asserted mid-INIT or mid-read:
  - `data_r`=0, `valid_r`=0 and the in-flight pipeline is flushed immediately.
  - `init_done`=0.
  - On release the sweep restarts from address 0.
- Reset values: `data_r`=0, `valid_r`=0, `init_done`=0 (=1 when INIT_ZERO=0), state=INIT/RUN as above, sweep counter=0.

## Structure
- Package `gen_sram_pkg`:
  - FSM state enum `sram_st_e` {INIT, RUN}.
  - Function `lanes(DW)`.
  - Constant for legal RD_LAT values.
- Sub-module `gen_sram_lane`: one 8-bit-wide, DP-deep storage lane with write enable and registered read. Instantiated (DW+7)/8 times in a generate loop.
- The top level holds the FSM, sweep counter, write mux between sweep and user port, collision/forward logic and the RD_LAT pipeline.

## Test plan
- Reset sweep, DW=32, AW=4:
  - `init_done` rises exactly 16 cycles after `RST` falls.
  - Reads of all 16 addresses return 0x00000000 with `valid_r` pulsing each cycle.
- Strobed write: write 0xAABBCCDD with strobe 4'b1111 to addr 3, then 0x11223344 with strobe 4'b0101. Read addr 3 → 0xAA22CC44.
- Collision, addr 5 holding 0x0: same-cycle write 0xDEADBEEF with strobe 4'b0011 and read.
  - BYPASS=1 → 0x0000BEEF.
  - BYPASS=0 → 0x00000000.
- RD_LAT=2:
  - Reads to addrs 1,2,3 on consecutive edges → `valid_r` high in cycles N+2..N+4 with matching data.
  - `data_r` holds the last value afterwards.
- `clear` in RUN:
  - `init_done` drops next cycle.
  - Reads issued during INIT produce no `valid_r`.
  - After 16 cycles all addresses read 0.
- DW=12:
  - Write 0xFFF with strobe 2'b10 over 0x000 → 0xF00.
  - `RST` pulse mid-sweep restarts the sweep and clears `valid_r` immediately.
